memory_writeback_phase: RTL



---
 rtl/memory_writeback_phase_if.sv | 38 +++
 rtl/memory_writeback_phase.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/memory_writeback_phase_if.sv
`default_nettype none
// ============================================================================
// Module      : memory_writeback_phase_if
// Description : Bundle between the execute phase, data memory read return and
//               the GPR write port of the writeback stage. The master drives
//               ew_*/mem_* and observes wb_*; the slave is the writeback stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface memory_writeback_phase_if #(
  parameter int REG_W      = 64,
  parameter int DATA_W     = 64,
  parameter int REG_ADDR_W = 5,
  parameter int OPCODE_W   = 8
);
  logic [OPCODE_W-1:0]   ew_opcode;
  logic [REG_ADDR_W-1:0] ew_reg_addr_d;
  logic [REG_W-1:0]      ew_d;
  logic [2:0]            ew_ld_offset;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_rvalid;
  logic                  wb_we;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [REG_W-1:0]      wb_data;
  logic                  wb_stall;
  logic                  wb_misalign;
  logic                  wb_timeout;

  modport master (
    output ew_opcode, ew_reg_addr_d, ew_d, ew_ld_offset, mem_rdata, mem_rvalid,
    input  wb_we, wb_addr, wb_data, wb_stall, wb_misalign, wb_timeout
  );

  modport slave (
    input  ew_opcode, ew_reg_addr_d, ew_d, ew_ld_offset, mem_rdata, mem_rvalid,
    output wb_we, wb_addr, wb_data, wb_stall, wb_misalign, wb_timeout
  );
endinterface
`default_nettype wire

// File: rtl/memory_writeback_phase.sv
`default_nettype none
// ============================================================================
// Module      : memory_writeback_phase
// Description : Final pipeline stage. ALU results are written to the GPR port
//               one cycle after acceptance; loads wait for the memory read
//               return, extract LB/LD/LQ data and stall upstream meanwhile.
//               Opcode map: LB=0x01 LD=0x02 LQ=0x03 SB=0x04 SD=0x05 SQ=0x06,
//               J* = 0x10..0x1F (JR=0x1E, JCX=0x1F), CMP=0x20 CMPI=0x21,
//               0x00 = bubble, everything else is an ALU write.
//               Optional load watchdog: define WB_LOAD_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_writeback_phase #(
  parameter int REG_W       = 64,
  parameter int DATA_W      = 64,
  parameter int REG_ADDR_W  = 5,
  parameter int OPCODE_W    = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  memory_writeback_phase_if.slave bus
);

  localparam logic [OPCODE_W-1:0] c_micro_lb   = OPCODE_W'(8'h01);
  localparam logic [OPCODE_W-1:0] c_micro_ld   = OPCODE_W'(8'h02);
  localparam logic [OPCODE_W-1:0] c_micro_lq   = OPCODE_W'(8'h03);
  localparam logic [OPCODE_W-1:0] c_micro_sb   = OPCODE_W'(8'h04);
  localparam logic [OPCODE_W-1:0] c_micro_sd   = OPCODE_W'(8'h05);
  localparam logic [OPCODE_W-1:0] c_micro_sq   = OPCODE_W'(8'h06);
  localparam logic [OPCODE_W-1:0] c_micro_cmp  = OPCODE_W'(8'h20);
  localparam logic [OPCODE_W-1:0] c_micro_cmpi = OPCODE_W'(8'h21);
  localparam logic [OPCODE_W-1:0] c_micro_jmsk = OPCODE_W'(8'hF0);
  localparam logic [OPCODE_W-1:0] c_micro_jcls = OPCODE_W'(8'h10);

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOAD_WAIT = 1'b1} state_t;

  state_t                r_state, w_state_nxt;
  logic [OPCODE_W-1:0]   r_ld_op;
  logic [REG_ADDR_W-1:0] r_ld_addr;
  logic [2:0]            r_ld_off;
  // An ALU op accepted on the same edge a load completes is parked here
  logic                  r_pend_vld, w_pend_vld_nxt;
  logic [REG_ADDR_W-1:0] r_pend_addr, w_pend_addr_nxt;
  logic [REG_W-1:0]      r_pend_data, w_pend_data_nxt;
  logic                  r_wb_we, w_we_nxt;
  logic [REG_ADDR_W-1:0] r_wb_addr, w_addr_nxt;
  logic [REG_W-1:0]      r_wb_data, w_data_nxt;
  logic                  r_wb_misalign, w_mis_nxt;
  logic                  w_capture;
  logic                  w_is_load, w_is_nowrite, w_rdone;
  logic [DATA_W-1:0]     w_lb_shift;
  logic [REG_W-1:0]      w_ld_data;
  logic                  w_ld_mis;

  // Opcode classification of the operation currently presented by execute
  always_comb begin
    w_is_load    = (bus.ew_opcode == c_micro_lb) || (bus.ew_opcode == c_micro_ld) ||
                   (bus.ew_opcode == c_micro_lq);
    w_is_nowrite = (bus.ew_opcode == '0) || (bus.ew_opcode == c_micro_sb) ||
                   (bus.ew_opcode == c_micro_sd) || (bus.ew_opcode == c_micro_sq) ||
                   ((bus.ew_opcode & c_micro_jmsk) == c_micro_jcls) ||
                   (bus.ew_opcode == c_micro_cmp) || (bus.ew_opcode == c_micro_cmpi);
  end

  // Load data extraction and alignment check from the latched load context
  always_comb begin
    w_lb_shift = bus.mem_rdata >> {r_ld_off, 3'b000};
    w_ld_data  = REG_W'(bus.mem_rdata);
    w_ld_mis   = 1'b0;
    if (r_ld_op == c_micro_lb) begin
      w_ld_data = REG_W'(w_lb_shift[7:0]);
    end else if (r_ld_op == c_micro_ld) begin
      w_ld_data = r_ld_off[2] ? REG_W'(bus.mem_rdata[32 +: 32]) : REG_W'(bus.mem_rdata[0 +: 32]);
      w_ld_mis  = (r_ld_off[1:0] != 2'b00);
    end else begin
      w_ld_mis  = (r_ld_off != 3'd0);
    end
  end

  assign w_rdone = (r_state == ST_LOAD_WAIT) && bus.mem_rvalid;

`ifdef WB_LOAD_TIMEOUT_EN
  localparam int c_cnt_w = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYC - 1);
  logic [c_cnt_w-1:0] r_to_cnt;
  logic               r_wb_timeout, w_to_nxt;

  assign w_to_nxt = (r_state == ST_LOAD_WAIT) && !bus.mem_rvalid && (r_to_cnt == c_cnt_last);

  // Watchdog: counts stalled LOAD_WAIT cycles, restarts on each load capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt     <= '0;
      r_wb_timeout <= 1'b0;
    end else begin
      r_wb_timeout <= w_to_nxt;
      if (w_capture) begin
        r_to_cnt <= '0;
      end else if ((r_state == ST_LOAD_WAIT) && !bus.mem_rvalid) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  assign bus.wb_timeout = r_wb_timeout;
`else
  assign bus.wb_timeout = 1'b0;
`endif

  // Next state and next write-port values
  always_comb begin
    w_state_nxt     = r_state;
    w_we_nxt        = 1'b0;
    w_addr_nxt      = r_wb_addr;
    w_data_nxt      = r_wb_data;
    w_mis_nxt       = 1'b0;
    w_pend_vld_nxt  = r_pend_vld;
    w_pend_addr_nxt = r_pend_addr;
    w_pend_data_nxt = r_pend_data;
    w_capture       = 1'b0;

    if (w_rdone) begin
      w_we_nxt    = 1'b1;
      w_addr_nxt  = r_ld_addr;
      w_data_nxt  = w_ld_data;
      w_mis_nxt   = w_ld_mis;
      w_state_nxt = ST_IDLE;
    end else if ((r_state == ST_IDLE) && r_pend_vld) begin
      w_we_nxt       = 1'b1;
      w_addr_nxt     = r_pend_addr;
      w_data_nxt     = r_pend_data;
      w_pend_vld_nxt = 1'b0;
    end

    // The stage accepts ew_* whenever it is not stalling upstream
    if ((r_state == ST_IDLE) || w_rdone) begin
      if (w_is_load) begin
        w_capture   = 1'b1;
        w_state_nxt = ST_LOAD_WAIT;
      end else if (!w_is_nowrite) begin
        if (w_we_nxt) begin
          w_pend_vld_nxt  = 1'b1;
          w_pend_addr_nxt = bus.ew_reg_addr_d;
          w_pend_data_nxt = bus.ew_d;
        end else begin
          w_we_nxt   = 1'b1;
          w_addr_nxt = bus.ew_reg_addr_d;
          w_data_nxt = bus.ew_d;
        end
      end
    end

`ifdef WB_LOAD_TIMEOUT_EN
    if (w_to_nxt) begin
      w_state_nxt = ST_IDLE;
    end
`endif
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Write port, parked ALU write and latched load context
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_we       <= 1'b0;
      r_wb_addr     <= '0;
      r_wb_data     <= '0;
      r_wb_misalign <= 1'b0;
      r_pend_vld    <= 1'b0;
      r_pend_addr   <= '0;
      r_pend_data   <= '0;
      r_ld_op       <= '0;
      r_ld_addr     <= '0;
      r_ld_off      <= '0;
    end else begin
      r_wb_we       <= w_we_nxt;
      r_wb_addr     <= w_addr_nxt;
      r_wb_data     <= w_data_nxt;
      r_wb_misalign <= w_mis_nxt;
      r_pend_vld    <= w_pend_vld_nxt;
      r_pend_addr   <= w_pend_addr_nxt;
      r_pend_data   <= w_pend_data_nxt;
      if (w_capture) begin
        r_ld_op   <= bus.ew_opcode;
        r_ld_addr <= bus.ew_reg_addr_d;
        r_ld_off  <= bus.ew_ld_offset;
      end
    end
  end

  assign bus.wb_we       = r_wb_we;
  assign bus.wb_addr     = r_wb_addr;
  assign bus.wb_data     = r_wb_data;
  assign bus.wb_misalign = r_wb_misalign;
  assign bus.wb_stall    = (r_state == ST_LOAD_WAIT) && !bus.mem_rvalid && !rst;

endmodule
`default_nettype wire
